cpu_wb_seq_divider: RTL and testbench

- Multi-cycle unsigned restoring divider; the inverse operation to the team's CLA multiplier datapath.
- Computes quotient and remainder of two DATA_WID-bit operands, one quotient bit per clock.
- Each trial subtraction uses a single instance of cpu_wb_cla_adder, DATA_WID+1 bits wide (in2 = ~divisor, carry_in = 1).
- Sits beside the multiplier in the execute/writeback path and uses a start/done handshake.

---
 rtl/cpu_wb_seq_divider.sv | 208 ++++++++++++++++++++
 tb/tb_cpu_wb_seq_divider.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_wb_seq_divider.sv
// ---------------------------------------------------------------------------
// cpu_wb_seq_divider
//   Multi-cycle unsigned restoring divider for the execute/writeback path.
//   Produces one quotient bit per clock using a single carry-lookahead adder
//   (DATA_WID+1 bits) for the trial subtraction.
//
// Ports:
//   clk         - rising-edge clock
//   rst         - asynchronous active-high reset
//   start       - division request, honoured only in IDLE or DONE
//   dividend    - numerator, captured on the accepting edge
//   divisor     - denominator, captured on the accepting edge
//   busy        - high while iterating (CALC)
//   done        - one-cycle pulse when quotient/remainder become valid
//   quotient    - registered quotient (all ones on divide by zero)
//   remainder   - registered remainder (dividend on divide by zero)
//   div_by_zero - set with done for a zero divisor, cleared on next accept
//
// Also contains cpu_wb_cla_adder, the generic carry-lookahead adder.
// ---------------------------------------------------------------------------

module cpu_wb_cla_adder #(
    parameter int WID = 33
) (
    input  logic [WID-1:0] in1,
    input  logic [WID-1:0] in2,
    input  logic           carry_in,
    output logic [WID-1:0] sum,
    output logic           carry_out
);
    logic [WID-1:0] gen_s;
    logic [WID-1:0] prop_s;
    logic [WID:0]   carry_s;

    assign gen_s  = in1 & in2;
    assign prop_s = in1 ^ in2;

    // Carry chain from generate/propagate terms; synthesis flattens it into lookahead logic.
    always_comb begin
        logic run_s;
        carry_s = {(WID+1){1'b0}};
        run_s   = carry_in;
        for (int i = 0; i < WID; i++) begin
            carry_s[i] = run_s;
            run_s      = gen_s[i] | (prop_s[i] & run_s);
        end
        carry_s[WID] = run_s;
    end

    assign sum       = prop_s ^ carry_s[WID-1:0];
    assign carry_out = carry_s[WID];
endmodule

module cpu_wb_seq_divider #(
    parameter int DATA_WID = 32,
    parameter int CNT_WID  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_WID-1:0] dividend,
    input  logic [DATA_WID-1:0] divisor,
    output logic                busy,
    output logic                done,
    output logic [DATA_WID-1:0] quotient,
    output logic [DATA_WID-1:0] remainder,
    output logic                div_by_zero
);
    // ST_DZ is a single wait cycle for a zero divisor so that done lands
    // one cycle after the accepting edge; busy stays low through it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DZ   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [DATA_WID-1:0] dq_r;          // dividend shifts out of the top, quotient bits shift in at the bottom
    logic [DATA_WID-1:0] dvs_r;
    logic [DATA_WID:0]   rem_r;         // partial remainder R
    logic [CNT_WID-1:0]  cnt_r;
    logic [DATA_WID-1:0] quotient_r;
    logic [DATA_WID-1:0] remainder_r;
    logic                dbz_r;

    logic [DATA_WID:0]   trial_s;
    logic [DATA_WID:0]   diff_s;
    logic [DATA_WID:0]   rem_next_s;
    logic [DATA_WID-1:0] dq_next_s;
    logic                no_borrow_s;
    logic                last_s;
    logic                divisor_zero_s;
    logic                unused_rem_msb_s;

    // R's MSB only ever holds 0 after an accepted subtraction; it never feeds the next trial.
    assign unused_rem_msb_s = rem_r[DATA_WID];

    assign trial_s        = {rem_r[DATA_WID-1:0], dq_r[DATA_WID-1]};
    assign last_s         = (cnt_r == CNT_WID'(DATA_WID - 1));
    assign divisor_zero_s = (divisor == {DATA_WID{1'b0}});

    // Trial subtraction T - {0, divisor}: carry_out = 1 means no borrow.
    cpu_wb_cla_adder #(
        .WID (DATA_WID + 1)
    ) u_trial_sub (
        .in1       (trial_s),
        .in2       (~{1'b0, dvs_r}),
        .carry_in  (1'b1),
        .sum       (diff_s),
        .carry_out (no_borrow_s)
    );

    // Restoring step: keep the difference when it did not borrow, else keep T.
    always_comb begin
        dq_next_s = {dq_r[DATA_WID-2:0], no_borrow_s};
        if (no_borrow_s) begin
            rem_next_s = diff_s;
        end else begin
            rem_next_s = trial_s;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; DONE accepts a new start exactly like IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (divisor_zero_s) begin
                        state_s = ST_DZ;
                    end else begin
                        state_s = ST_CALC;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_CALC;
                end
            end
            ST_DZ:   state_s = ST_DONE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result registers loaded only on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq_r        <= {DATA_WID{1'b0}};
            dvs_r       <= {DATA_WID{1'b0}};
            rem_r       <= {(DATA_WID+1){1'b0}};
            cnt_r       <= {CNT_WID{1'b0}};
            quotient_r  <= {DATA_WID{1'b0}};
            remainder_r <= {DATA_WID{1'b0}};
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        dq_r  <= dividend;
                        dvs_r <= divisor;
                        rem_r <= {(DATA_WID+1){1'b0}};
                        cnt_r <= {CNT_WID{1'b0}};
                        dbz_r <= 1'b0;
                    end
                end
                ST_CALC: begin
                    rem_r <= rem_next_s;
                    dq_r  <= dq_next_s;
                    cnt_r <= cnt_r + CNT_WID'(1);
                    if (last_s) begin
                        quotient_r  <= dq_next_s;
                        remainder_r <= rem_next_s[DATA_WID-1:0];
                    end
                end
                ST_DZ: begin
                    quotient_r  <= {DATA_WID{1'b1}};
                    remainder_r <= dq_r;
                    dbz_r       <= 1'b1;
                end
                default: begin
                    dbz_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = (state_r == ST_CALC);
    assign done        = (state_r == ST_DONE);
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;
endmodule

// File: tb/tb_cpu_wb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_cpu_wb_seq_divider
//   Directed and random stimulus for cpu_wb_seq_divider. A driver issues
//   start pulses and pushes the expected response (from plain / and %) into
//   a scoreboard queue; a monitor pops and compares on every done pulse and
//   also checks busy and the held result registers every cycle.
// ---------------------------------------------------------------------------
module tb_cpu_wb_seq_divider;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    cpu_wb_seq_divider #(.DATA_WID(W), .CNT_WID(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           acc;   // accepting edge
        int           due;   // edge after which done must be high
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         nz;
    } op_t;

    op_t          sb[$];
    int           n_tests   = 0;
    int           n_fail    = 0;
    int           next_free = 0;
    logic [W-1:0] hold_q    = '0;
    logic [W-1:0] hold_r    = '0;
    logic         hold_dbz  = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic op_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
        op_t o;
        o.acc = acc;
        o.a   = a;
        o.b   = b;
        if (b == 0) begin
            o.q   = '1;
            o.r   = a;
            o.dbz = 1'b1;
            o.nz  = 1'b0;
            o.due = acc + 1;
        end else begin
            o.q   = a / b;
            o.r   = a % b;
            o.dbz = 1'b0;
            o.nz  = 1'b1;
            o.due = acc + W;
        end
        return o;
    endfunction

    // Called right after a negedge; leaves at the following negedge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        op_t o;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        if (cyc + 1 >= next_free) begin
            o = model(a, b, cyc + 1);
            sb.push_back(o);
            next_free = o.due + 1;
        end
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic wait_free();
        while (cyc + 1 < next_free) @(negedge clk);
    endtask

    // Monitor: compare on done, and check busy/held outputs every cycle.
    initial begin
        op_t  f;
        logic exp_busy;
        logic [63:0] recon;
        forever begin
            @(posedge clk);
            #1;
            exp_busy = 1'b0;
            if (sb.size() > 0 && cyc >= sb[0].acc) begin
                hold_dbz = 1'b0;
                if (sb[0].nz && cyc < sb[0].due) exp_busy = 1'b1;
            end
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", done, 1'b0);
                end else begin
                    f = sb.pop_front();
                    check("latency", cyc, f.due);
                    check("quotient", quotient, f.q);
                    check("remainder", remainder, f.r);
                    check("div_by_zero", div_by_zero, f.dbz);
                    if (f.nz) begin
                        recon = 64'(quotient) * 64'(f.b) + 64'(remainder);
                        check("invariant", {recon == 64'(f.a), remainder < f.b}, 2'b11);
                    end
                    hold_q   = f.q;
                    hold_r   = f.r;
                    hold_dbz = f.dbz;
                end
            end else if (sb.size() > 0 && cyc >= sb[0].due) begin
                f = sb.pop_front();
                check("done_timeout", done, 1'b1);
            end
            check("outputs_held", {busy, quotient, remainder, div_by_zero},
                  {exp_busy, hold_q, hold_r, hold_dbz});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           sel;
        int           gap;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {busy, done, quotient, remainder, div_by_zero}, '0);
        rst = 1'b0;
        @(negedge clk);

        // Basic and extremes
        issue(32'd100, 32'd7);               wait_free();
        issue(32'hFFFF_FFFF, 32'd1);         wait_free();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_free();
        issue(32'd5, 32'd9);                 wait_free();
        issue(32'h0000_1234, 32'd0);         wait_free();

        // start during CALC is ignored
        issue(32'd100, 32'd7);
        repeat (8) @(negedge clk);
        issue(32'd50, 32'd3);
        wait_free();

        // Back-to-back: second start in the done cycle
        issue(32'd100, 32'd7);
        wait_free();
        issue(32'd50, 32'd3);
        wait_free();

        // Asynchronous reset at iteration 17
        issue(32'd100, 32'd7);
        repeat (17) @(negedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        hold_q    = '0;
        hold_r    = '0;
        hold_dbz  = 1'b0;
        next_free = 0;
        #1;
        check("reset_mid_op", {busy, done, quotient, remainder, div_by_zero}, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(32'd9, 32'd2);
        wait_free();

        // Random operands, random gaps, occasional start while busy
        for (int i = 0; i < 1200; i++) begin
            sel = $urandom_range(0, 7);
            a   = $urandom;
            b   = $urandom >> $urandom_range(0, 31);
            case (sel)
                0: b = 32'd1;
                1: b = 32'd1 << $urandom_range(0, 31);
                2: a = 32'd0;
                3: b = 32'd0;
                4: begin a = $urandom_range(0, 255); b = $urandom_range(1, 16); end
                5: begin a = $urandom_range(0, 1000); b = a + $urandom_range(0, 1000); end
                default: ;
            endcase
            issue(a, b);
            gap = $urandom_range(0, 3);
            if (gap == 3) issue($urandom, $urandom);
            wait_free();
            repeat (gap) @(negedge clk);
        end

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        check("drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
